// File: rtl/data_mem_mmio_if.sv
// Data memory bus between the MEM stage and data_mem_mmio.
// Carries the load/store request, the load response and the MMIO words.
interface data_mem_mmio_if #(
  parameter int ADDR_W = 10,
  parameter int N_IN   = 1,
  parameter int N_OUT  = 1
);
  logic [ADDR_W+1:0]    addr;
  logic                 re;
  logic                 we;
  logic [1:0]           size;
  logic                 uns;
  logic [31:0]          wdata;
  logic [32*N_IN-1:0]   in_d;
  logic [31:0]          rdata;
  logic                 rvalid;
  logic                 err;
  logic [32*N_OUT-1:0]  out_d;
  logic [N_OUT-1:0]     out_stb;

  modport master (
    output addr, re, we, size, uns, wdata, in_d,
    input  rdata, rvalid, err, out_d, out_stb
  );

  modport slave (
    input  addr, re, we, size, uns, wdata, in_d,
    output rdata, rvalid, err, out_d, out_stb
  );
endinterface

// File: rtl/data_mem_mmio.sv
// RV32 byte-addressable data memory with memory-mapped input/output words.
// Optional macro DMEM_MISALIGN_CHK_EN enables misaligned-access trapping.
module data_mem_mmio #(
  parameter int ADDR_W   = 10,
  parameter int N_IN     = 1,
  parameter int N_OUT    = 1,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 1
) (
  input  logic         clk,
  input  logic         rst,
  data_mem_mmio_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IN_B  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_B = ADDR_W'(OUT_BASE);

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic [ADDR_W-1:0] in_rel;
  logic [ADDR_W-1:0] out_rel;
  logic [N_IN-1:0]   hit_in;
  logic [N_OUT-1:0]  hit_out;
  logic              is_io;

  logic [1:0]  off_eff;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic        mis_act;
  logic        st_ok;
  logic        ram_we;

  logic [3:0][7:0] mem_q [DEPTH];
  logic [3:0][7:0] ram_rd_q;

  logic [31:0]      in_q  [N_IN];
  logic [31:0]      out_q [N_OUT];
  logic [N_OUT-1:0] out_stb_q;

  logic             rvalid_q;
  logic [1:0]       rsz_q;
  logic [1:0]       roff_q;
  logic             runs_q;
  logic             rmis_q;
  logic [N_IN-1:0]  rin_q;
  logic [N_OUT-1:0] rout_q;

  logic [31:0] rword;
  logic [31:0] rsh;
  logic [31:0] rext;

  assign idx     = bus.addr[ADDR_W+1:2];
  assign off     = bus.addr[1:0];
  assign in_rel  = idx - IN_B;
  assign out_rel = idx - OUT_B;

  // Decode which MMIO word, if any, the current address hits
  always_comb begin
    hit_in  = '0;
    hit_out = '0;
    for (int j = 0; j < N_IN; j++)
      hit_in[j] = (in_rel == ADDR_W'(j));
    for (int k = 0; k < N_OUT; k++)
      hit_out[k] = (out_rel == ADDR_W'(k));
    is_io = (|hit_in) | (|hit_out);
  end

  // Byte-lane enables and lane-replicated store data per access size
  always_comb begin
    off_eff = 2'b00;
    be      = 4'b1111;
    wlane   = bus.wdata;
    unique case (1'b1)
      (bus.size == 2'b00): begin
        off_eff = off;
        be      = 4'b0001 << off;
        wlane   = {4{bus.wdata[7:0]}};
      end
      (bus.size == 2'b01): begin
        off_eff = {off[1], 1'b0};
        be      = 4'b0011 << {off[1], 1'b0};
        wlane   = {2{bus.wdata[15:0]}};
      end
      default: begin
        off_eff = 2'b00;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_CHK_EN
  // Half needs addr[0]=0, word needs addr[1:0]=0
  assign mis_act = (bus.size == 2'b01) ? off[0] :
                   bus.size[1] ? (|off) : 1'b0;
`else
  assign mis_act = 1'b0;
`endif

  assign st_ok  = bus.we & ~mis_act;
  assign ram_we = st_ok & ~is_io;

  // Block RAM with byte-lane writes and a write-first read port
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && be[b])
        mem_q[idx][b] <= wlane[8*b +: 8];
      if (bus.re)
        ram_rd_q[b] <= (ram_we && be[b]) ?
                       wlane[8*b +: 8] : mem_q[idx][b];
    end
  end

  // Input sampling, output registers and strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_IN; j++)
        in_q[j] <= '0;
      for (int k = 0; k < N_OUT; k++)
        out_q[k] <= '0;
      out_stb_q <= '0;
    end else begin
      for (int j = 0; j < N_IN; j++)
        in_q[j] <= bus.in_d[32*j +: 32];
      for (int k = 0; k < N_OUT; k++) begin
        out_stb_q[k] <= st_ok & hit_out[k];
        for (int b = 0; b < 4; b++)
          if (st_ok && hit_out[k] && be[b])
            out_q[k][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Load request register: one response the cycle after each re
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rsz_q    <= 2'b00;
      roff_q   <= 2'b00;
      runs_q   <= 1'b0;
      rmis_q   <= 1'b0;
      rin_q    <= '0;
      rout_q   <= '0;
    end else begin
      rvalid_q <= bus.re;
      if (bus.re) begin
        rsz_q  <= bus.size;
        roff_q <= off_eff;
        runs_q <= bus.uns;
        rmis_q <= mis_act;
        rin_q  <= hit_in;
        rout_q <= hit_out;
      end
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic err_q;

  // Flag a misaligned load or store in the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= mis_act & (bus.re | bus.we);
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Select source word, align the lanes and extend
  always_comb begin
    rword = ram_rd_q;
    for (int j = 0; j < N_IN; j++)
      if (rin_q[j]) rword = in_q[j];
    for (int k = 0; k < N_OUT; k++)
      if (rout_q[k]) rword = out_q[k];
    rsh  = rword >> {roff_q, 3'b000};
    rext = rsh;
    unique case (1'b1)
      (rsz_q == 2'b00):
        rext = {{24{~runs_q & rsh[7]}}, rsh[7:0]};
      (rsz_q == 2'b01):
        rext = {{16{~runs_q & rsh[15]}}, rsh[15:0]};
      default:
        rext = rsh;
    endcase
  end

  // Drive the packed output word bus
  always_comb begin
    bus.out_d = '0;
    for (int k = 0; k < N_OUT; k++)
      bus.out_d[32*k +: 32] = out_q[k];
  end

  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = (rvalid_q & ~rmis_q) ? rext : 32'h0;
  assign bus.out_stb = out_stb_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Testbench for data_mem_mmio: directed table, corner sequences,
// and random traffic against a byte-level reference model.
module tb_data_mem_mmio;
  localparam int AW = 10;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int IB = 48;
  localparam int OB = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_mmio_if #(.ADDR_W(AW), .N_IN(NI), .N_OUT(NO)) bus ();

  data_mem_mmio #(
    .ADDR_W(AW), .N_IN(NI), .N_OUT(NO),
    .IN_BASE(IB), .OUT_BASE(OB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0]  ram_m [4096];
  logic [31:0] in_m  [NI];
  logic [31:0] out_m [NO];
  logic        e_rv;
  logic [31:0] e_rd;
  logic        e_err;
  logic [NO-1:0] e_stb;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [7:0] get_b(int b);
    int w = b / 4;
    int l = b % 4;
    if (w >= IB && w < IB + NI) return in_m[w-IB][8*l +: 8];
    if (w >= OB && w < OB + NO) return out_m[w-OB][8*l +: 8];
    return ram_m[b];
  endfunction

  task automatic put_b(int b, logic [7:0] d);
    int w = b / 4;
    int l = b % 4;
    if (w >= IB && w < IB + NI) return;
    if (w >= OB && w < OB + NO) begin
      out_m[w-OB][8*l +: 8] = d;
      e_stb[w-OB] = 1'b1;
    end else begin
      ram_m[b] = d;
    end
  endtask

  task automatic model(input logic re, input logic we,
                       input logic [11:0] ad, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       input logic [63:0] ind);
    int nb;
    int a;
    logic mis;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a  = (int'(ad) / nb) * nb;
`ifdef DMEM_MISALIGN_CHK_EN
    mis = (int'(ad) % nb) != 0;
`else
    mis = 1'b0;
`endif
    for (int j = 0; j < NI; j++) in_m[j] = ind[32*j +: 32];
    e_stb = '0;
    e_err = 1'b0;
    e_rv  = re;
    e_rd  = 32'h0;
    if (we && mis) e_err = 1'b1;
    else if (we)
      for (int i = 0; i < nb; i++) put_b(a + i, wd[8*i +: 8]);
    if (re) begin
      if (mis) e_err = 1'b1;
      else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = get_b(a + i);
        if (!u && nb < 4 && v[8*nb-1])
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        e_rd = v;
      end
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < NI; j++) in_m[j] = 32'h0;
    for (int k = 0; k < NO; k++) out_m[k] = 32'h0;
    e_stb = '0;
    e_rv  = 1'b0;
    e_err = 1'b0;
  endtask

  task automatic drive(input logic re, input logic we,
                       input logic [11:0] ad, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       input logic [63:0] ind);
    @(negedge clk);
    bus.re = re; bus.we = we; bus.addr = ad;
    bus.size = sz; bus.uns = u; bus.wdata = wd; bus.in_d = ind;
    model(re, we, ad, sz, u, wd, ind);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [11:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [63:0] in_d;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [1:0]  e_stb;
    logic [31:0] e_out0;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bus.re = 0; bus.we = 0; bus.addr = '0; bus.size = 0;
    bus.uns = 0; bus.wdata = 0; bus.in_d = '0;
    model_reset();

    tbl.push_back('{0,1,12'h00C,2,0,32'h01020304,64'h0,0,32'h0,2'b00,32'h0});
    tbl.push_back('{0,1,12'h00C,0,0,32'h00000080,64'h0,0,32'h0,2'b00,32'h0});
    tbl.push_back('{1,0,12'h00C,0,0,32'h0,64'h0,1,32'hFFFFFF80,2'b00,32'h0});
    tbl.push_back('{1,0,12'h00C,0,1,32'h0,64'h0,1,32'h00000080,2'b00,32'h0});
    tbl.push_back('{1,0,12'h00C,2,0,32'h0,64'h0,1,32'h01020380,2'b00,32'h0});
    tbl.push_back('{0,1,12'h010,2,0,32'h11223344,64'h0,0,32'h0,2'b00,32'h0});
    tbl.push_back('{0,1,12'h012,1,0,32'h0000BEEF,64'h0,0,32'h0,2'b00,32'h0});
    tbl.push_back('{1,0,12'h010,2,0,32'h0,64'h0,1,32'hBEEF3344,2'b00,32'h0});
    tbl.push_back('{1,0,12'h012,1,0,32'h0,64'h0,1,32'hFFFFBEEF,2'b00,32'h0});
    tbl.push_back('{1,0,12'h012,1,1,32'h0,64'h0,1,32'h0000BEEF,2'b00,32'h0});
    tbl.push_back('{1,0,12'h013,0,0,32'h0,64'h0,1,32'hFFFFFFBE,2'b00,32'h0});
    tbl.push_back('{1,0,12'h011,0,1,32'h0,64'h0,1,32'h00000033,2'b00,32'h0});
    tbl.push_back('{1,0,12'h0C0,2,0,32'h0,64'h16,1,32'h00000016,2'b00,32'h0});
    tbl.push_back('{0,1,12'h0C0,2,0,32'h5,64'h16,0,32'h0,2'b00,32'h0});
    tbl.push_back('{1,0,12'h0C0,2,0,32'h0,64'h16,1,32'h00000016,2'b00,32'h0});
    tbl.push_back('{1,0,12'h0C6,1,0,32'h0,64'h80010000_00000016,1,32'hFFFF8001,2'b00,32'h0});
    tbl.push_back('{0,1,12'h0C8,2,0,32'hCAFE0001,64'h0,0,32'h0,2'b01,32'hCAFE0001});
    tbl.push_back('{0,0,12'h000,0,0,32'h0,64'h0,0,32'h0,2'b00,32'hCAFE0001});
    tbl.push_back('{1,1,12'h020,2,0,32'hA5A5A5A5,64'h0,1,32'hA5A5A5A5,2'b00,32'hCAFE0001});
    tbl.push_back('{1,1,12'h0C9,0,0,32'h7F,64'h0,1,32'h0000007F,2'b01,32'hCAFE7F01});
    tbl.push_back('{1,0,12'h0C8,2,0,32'h0,64'h0,1,32'hCAFE7F01,2'b00,32'hCAFE7F01});
    tbl.push_back('{0,1,12'h0CC,1,0,32'h1234,64'h0,0,32'h0,2'b10,32'hCAFE7F01});
    tbl.push_back('{1,1,12'h0C4,2,0,32'hFFFFFFFF,64'h12345678_00000016,1,32'h12345678,2'b00,32'hCAFE7F01});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
    chk("rst_rdata",  64'(bus.rdata),  64'h0);
    chk("rst_err",    64'(bus.err),    64'h0);
    chk("rst_out_d",  64'(bus.out_d),  64'h0);
    chk("rst_stb",    64'(bus.out_stb), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].size,
            tbl[i].uns, tbl[i].wdata, tbl[i].in_d);
      chk($sformatf("tbl%0d_rvalid", i), 64'(bus.rvalid), 64'(tbl[i].e_rv));
      if (tbl[i].e_rv)
        chk($sformatf("tbl%0d_rdata", i), 64'(bus.rdata), 64'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_stb", i), 64'(bus.out_stb), 64'(tbl[i].e_stb));
      chk($sformatf("tbl%0d_out0", i), 64'(bus.out_d[31:0]), 64'(tbl[i].e_out0));
      chk($sformatf("tbl%0d_err", i), 64'(bus.err), 64'h0);
    end
    chk("tbl_out1", 64'(bus.out_d[63:32]), 64'h00001234);

    drive(1, 0, 12'h010, 2, 0, 32'h0, 64'h0);
    chk("pend_rvalid", 64'(bus.rvalid), 64'h1);
    chk("pend_rdata",  64'(bus.rdata),  64'hBEEF3344);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_rvalid", 64'(bus.rvalid), 64'h0);
    chk("arst_out_d",  64'(bus.out_d),  64'h0);
    chk("arst_stb",    64'(bus.out_stb), 64'h0);
    @(negedge clk);
    bus.re = 0; bus.we = 0;
    @(negedge clk);
    rst = 1'b0;

`ifdef DMEM_MISALIGN_CHK_EN
    drive(1, 0, 12'h021, 2, 0, 32'h0, 64'h0);
    chk("mis_ld_rvalid", 64'(bus.rvalid), 64'h1);
    chk("mis_ld_err",    64'(bus.err),    64'h1);
    chk("mis_ld_rdata",  64'(bus.rdata),  64'h0);
    drive(0, 1, 12'h022, 2, 0, 32'hDEADBEEF, 64'h0);
    chk("mis_st_err", 64'(bus.err), 64'h1);
    drive(1, 0, 12'h020, 2, 0, 32'h0, 64'h0);
    chk("mis_st_kept", 64'(bus.rdata), 64'hA5A5A5A5);
    chk("mis_st_err0", 64'(bus.err), 64'h0);
`else
    drive(1, 0, 12'h021, 2, 0, 32'h0, 64'h0);
    chk("ign_lw_rdata", 64'(bus.rdata), 64'hA5A5A5A5);
    chk("ign_lw_err",   64'(bus.err),   64'h0);
    drive(0, 1, 12'h023, 1, 0, 32'h1234, 64'h0);
    drive(1, 0, 12'h021, 1, 1, 32'h0, 64'h0);
    chk("ign_lhu_rdata", 64'(bus.rdata), 64'h0000A5A5);
    drive(1, 0, 12'h020, 2, 0, 32'h0, 64'h0);
    chk("ign_sh_word", 64'(bus.rdata), 64'h1234A5A5);
`endif

    for (int w = 0; w < 16; w++)
      drive(0, 1, 12'(w*4), 2, 0, $urandom, 64'h0);
    for (int w = 1020; w < 1024; w++)
      drive(0, 1, 12'(w*4), 2, 0, $urandom, 64'h0);

    for (int n = 0; n < 1500; n++) begin
      int s;
      int w;
      s = $urandom_range(0, 23);
      w = (s < 16) ? s : (s < 20) ? (IB + s - 16) : (1020 + s - 20);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            12'(w*4 + $urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom,
            {$urandom, $urandom});
      chk("rnd_rvalid", 64'(bus.rvalid), 64'(e_rv));
      if (e_rv)
        chk("rnd_rdata", 64'(bus.rdata), 64'(e_rd));
      chk("rnd_err", 64'(bus.err), 64'(e_err));
      chk("rnd_out_d", 64'(bus.out_d), {out_m[1], out_m[0]});
      chk("rnd_stb", 64'(bus.out_stb), 64'(e_stb));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
